asic_iopoc_ctrl: RTL and testbench

- Power-on-control (POC) sequencer that drives the padring `poc` net.
- The padring feeds `poc` through every IO cell and supply-cut cell. This block is the single source for it, placed in the always-on core domain next to the padring.
- Holds all IO cells in their safe state until both supplies are confirmed stable for a programmable settle time. Then it releases `poc` and signals IO readiness.
- Re-asserts `poc` on supply loss and on orderly shutdown.

---
 rtl/asic_iopoc_ctrl_if.sv | 22 ++
 rtl/asic_iopoc_ctrl.sv | 144 ++++++++++++++
 tb/tb_asic_iopoc_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/asic_iopoc_ctrl_if.sv
// Control and status bundle between the POC sequencer and its environment.
// The master side drives power-up requests and supply indications; the slave is the sequencer.
interface asic_iopoc_ctrl_if;
    logic       en;
    logic       vddio_ok;
    logic       vdd_ok;
    logic       fault_clr;
    logic       poc;
    logic       io_ready;
    logic       fault;
    logic [2:0] state;

    modport master (
        output en, vddio_ok, vdd_ok, fault_clr,
        input  poc, io_ready, fault, state
    );

    modport slave (
        input  en, vddio_ok, vdd_ok, fault_clr,
        output poc, io_ready, fault, state
    );
endinterface

// File: rtl/asic_iopoc_ctrl.sv
// Power-on-control sequencer for the padring poc net: holds IOs safe until both
// supplies have been stable for a settle time, then releases poc and flags io_ready.
//
// state    | meaning
// IDLE     | poc asserted, waiting for en and both supplies good
// SETTLE   | supplies good, counting the settle time, poc still asserted
// RELEASE  | poc released, waiting before declaring IOs ready
// ACTIVE   | poc released, io_ready asserted
// SHUTDOWN | io_ready dropped, poc rises on the next edge
// FAULT    | supply lost after release; poc asserted, sticky fault set
module asic_iopoc_ctrl #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int RELEASE_CYCLES = 16,
    parameter int CW             = 16
) (
    input  logic clk,
    input  logic reset,
    asic_iopoc_ctrl_if.slave io
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        RELEASE  = 3'd2,
        ACTIVE   = 3'd3,
        SHUTDOWN = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam logic [CW-1:0] SETTLE_TC  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RELEASE_TC = CW'(RELEASE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    logic [SYNC_STAGES-1:0] vddio_sync;
    logic [SYNC_STAGES-1:0] vdd_sync;
    logic                   sup_ok;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          poc_q;
    logic          io_ready_q;
    logic          fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vddio_sync <= '0;
            vdd_sync   <= '0;
        end else begin
            vddio_sync <= {vddio_sync[SYNC_STAGES-2:0], io.vddio_ok};
            vdd_sync   <= {vdd_sync[SYNC_STAGES-2:0], io.vdd_ok};
        end
    end

    assign sup_ok = vddio_sync[SYNC_STAGES-1] & vdd_sync[SYNC_STAGES-1];

    // Outputs are registered alongside the state so poc and io_ready change on the transition edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            poc_q      <= 1'b1;
            io_ready_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (io.en && sup_ok) begin
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!sup_ok || !io.en) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == SETTLE_TC) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                        poc_q   <= 1'b0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (!sup_ok) begin
                        state_q <= FAULT;
                        cnt_q   <= '0;
                        poc_q   <= 1'b1;
                        fault_q <= 1'b1;
                    end else if (!io.en) begin
                        state_q <= SHUTDOWN;
                        cnt_q   <= '0;
                    end else if (cnt_q == RELEASE_TC) begin
                        state_q    <= ACTIVE;
                        cnt_q      <= '0;
                        io_ready_q <= 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                ACTIVE: begin
                    if (!sup_ok) begin
                        state_q    <= FAULT;
                        poc_q      <= 1'b1;
                        io_ready_q <= 1'b0;
                        fault_q    <= 1'b1;
                    end else if (!io.en) begin
                        state_q    <= SHUTDOWN;
                        io_ready_q <= 1'b0;
                    end
                end
                SHUTDOWN: begin
                    state_q <= IDLE;
                    poc_q   <= 1'b1;
                end
                FAULT: begin
                    if (io.fault_clr && sup_ok) begin
                        state_q <= IDLE;
                        fault_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    cnt_q      <= '0;
                    poc_q      <= 1'b1;
                    io_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign io.poc      = poc_q;
    assign io.io_ready = io_ready_q;
    assign io.fault    = fault_q;
    assign io.state    = state_q;

    // Counter must leave its phase at terminal count; reaching beyond it means the FSM is broken.
    a_settle_bound: assert property (@(posedge clk) disable iff (reset)
        (state_q == SETTLE) |-> (cnt_q <= SETTLE_TC));
    a_release_bound: assert property (@(posedge clk) disable iff (reset)
        (state_q == RELEASE) |-> (cnt_q <= RELEASE_TC));

endmodule

// File: tb/tb_asic_iopoc_ctrl.sv
// Bench for the POC sequencer: a phase/time based reference model checked every cycle,
// plus literal cycle expectations for power-up, glitch, fault, shutdown and reset scenarios.
module tb_asic_iopoc_ctrl;

    localparam int SYNC = 2;
    localparam int SET  = 8;
    localparam int REL  = 4;

    localparam int M_IDLE     = 0;
    localparam int M_SETTLE   = 1;
    localparam int M_RELEASE  = 2;
    localparam int M_ACTIVE   = 3;
    localparam int M_SHUTDOWN = 4;
    localparam int M_FAULT    = 5;

    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    asic_iopoc_ctrl_if io ();

    asic_iopoc_ctrl #(
        .SYNC_STAGES   (SYNC),
        .SETTLE_CYCLES (SET),
        .RELEASE_CYCLES(REL),
        .CW            (16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .io   (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: mode plus the edge number at which the current timed phase began.
    int m_mode  = M_IDLE;
    int m_edge  = 0;
    int m_entry = 0;
    bit okq[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  = M_IDLE;
            m_edge  = 0;
            m_entry = 0;
            okq     = {};
            for (int i = 0; i < SYNC; i++) okq.push_front(1'b0);
        end else begin
            bit sup;
            sup = okq.pop_back();
            okq.push_front(io.vddio_ok && io.vdd_ok);
            m_edge++;
            case (m_mode)
                M_IDLE:
                    if (io.en && sup) begin
                        m_mode  = M_SETTLE;
                        m_entry = m_edge;
                    end
                M_SETTLE:
                    if (!(io.en && sup)) m_mode = M_IDLE;
                    else if (m_edge - m_entry == SET) begin
                        m_mode  = M_RELEASE;
                        m_entry = m_edge;
                    end
                M_RELEASE:
                    if (!sup) m_mode = M_FAULT;
                    else if (!io.en) m_mode = M_SHUTDOWN;
                    else if (m_edge - m_entry == REL) m_mode = M_ACTIVE;
                M_ACTIVE:
                    if (!sup) m_mode = M_FAULT;
                    else if (!io.en) m_mode = M_SHUTDOWN;
                M_SHUTDOWN: m_mode = M_IDLE;
                M_FAULT:
                    if (io.fault_clr && sup) m_mode = M_IDLE;
                default: m_mode = M_IDLE;
            endcase
        end
    end

    function automatic logic exp_poc(input int m);
        return !(m == M_RELEASE || m == M_ACTIVE || m == M_SHUTDOWN);
    endfunction

    always @(negedge clk) begin
        chk("model_poc",      io.poc,      exp_poc(m_mode));
        chk("model_io_ready", io.io_ready, (m_mode == M_ACTIVE));
        chk("model_fault",    io.fault,    (m_mode == M_FAULT));
        chk("model_state",    io.state,    m_mode);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_for_state(input int s, input int budget);
        int n = 0;
        while (io.state != 3'(s) && n < budget) begin
            step(1);
            n++;
        end
        chk("wait_state", io.state, s);
    endtask

    // Called at the negedge where reset drops and en/supplies are already high (cycle 0).
    task automatic powerup_literals();
        step(2);
        chk("pu_state_c2", io.state, 0);
        step(1);
        chk("pu_state_c3", io.state, 1);
        chk("pu_poc_c3", io.poc, 1);
        step(7);
        chk("pu_poc_c10", io.poc, 1);
        step(1);
        chk("pu_poc_c11", io.poc, 0);
        chk("pu_state_c11", io.state, 2);
        step(3);
        chk("pu_ready_c14", io.io_ready, 0);
        step(1);
        chk("pu_ready_c15", io.io_ready, 1);
        chk("pu_state_c15", io.state, 3);
        chk("pu_fault_c15", io.fault, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt;
        reset        = 1'b0;
        io.en        = 1'b0;
        io.vddio_ok  = 1'b0;
        io.vdd_ok    = 1'b0;
        io.fault_clr = 1'b0;
        #1 reset = 1'b1;
        step(2);
        chk("rst_poc", io.poc, 1);
        chk("rst_ready", io.io_ready, 0);
        chk("rst_state", io.state, 0);

        // Power-up with everything good from cycle 0.
        io.en       = 1'b1;
        io.vddio_ok = 1'b1;
        io.vdd_ok   = 1'b1;
        reset       = 1'b0;
        powerup_literals();

        // Orderly shutdown from ACTIVE.
        io.en = 1'b0;
        step(1);
        chk("sd_state", io.state, 4);
        chk("sd_ready", io.io_ready, 0);
        chk("sd_poc_low", io.poc, 0);
        step(1);
        chk("sd_poc_high", io.poc, 1);
        chk("sd_idle", io.state, 0);

        // vdd_ok glitch during SETTLE.
        io.en = 1'b1;
        step(4);
        chk("gl_settle", io.state, 1);
        io.vdd_ok = 1'b0;
        step(3);
        io.vdd_ok = 1'b1;
        chk("gl_idle", io.state, 0);
        chk("gl_poc", io.poc, 1);
        wait_for_state(1, 10);
        cnt = 0;
        while (io.poc && cnt < 20) begin
            step(1);
            cnt++;
        end
        chk("gl_resettle_len", cnt, SET);

        // Supply loss in ACTIVE, then fault clear handling.
        wait_for_state(3, 20);
        io.vddio_ok = 1'b0;
        step(2);
        chk("fl_still_active", io.state, 3);
        step(1);
        chk("fl_state", io.state, 5);
        chk("fl_poc", io.poc, 1);
        chk("fl_ready", io.io_ready, 0);
        chk("fl_fault", io.fault, 1);
        io.fault_clr = 1'b1;
        step(1);
        io.fault_clr = 1'b0;
        chk("fl_clr_ignored", io.state, 5);
        io.vddio_ok = 1'b1;
        io.en       = 1'b0;
        step(3);
        chk("fl_sticky", io.fault, 1);
        io.fault_clr = 1'b1;
        step(1);
        io.fault_clr = 1'b0;
        chk("fl_clr_state", io.state, 0);
        chk("fl_clr_fault", io.fault, 0);
        io.fault_clr = 1'b1;
        step(1);
        io.fault_clr = 1'b0;
        chk("clr_in_idle", io.state, 0);

        // en drop and supply loss reach the FSM on the same edge.
        io.en = 1'b1;
        wait_for_state(3, 30);
        io.vdd_ok = 1'b0;
        step(2);
        chk("both_pre", io.state, 3);
        io.en = 1'b0;
        step(1);
        chk("both_state", io.state, 5);
        chk("both_poc", io.poc, 1);
        chk("both_fault", io.fault, 1);
        io.vdd_ok = 1'b1;
        step(3);
        io.fault_clr = 1'b1;
        step(1);
        io.fault_clr = 1'b0;
        chk("both_clr", io.state, 0);

        // Asynchronous reset in the middle of RELEASE.
        io.en = 1'b1;
        wait_for_state(2, 30);
        step(1);
        #2 reset = 1'b1;
        #1;
        chk("ar_poc", io.poc, 1);
        chk("ar_ready", io.io_ready, 0);
        chk("ar_state", io.state, 0);
        chk("ar_fault", io.fault, 0);
        step(2);
        reset = 1'b0;
        powerup_literals();

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
